// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared types and constants for serial_word_deserializer.
//   - deser_state_t    : receive FSM state (IDLE, SHIFT, PARITY)
//   - ST_ENC_*         : state encodings backing the enum
//   - WIDTH_MIN/MAX    : legal range of the WIDTH parameter
// Optional feature macro: DESER_PARITY_EN (trailing even-parity bit per frame).
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam logic [1:0] ST_ENC_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENC_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ENC_PARITY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_ENC_IDLE,
        ST_SHIFT  = ST_ENC_SHIFT,
        ST_PARITY = ST_ENC_PARITY
    } deser_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/deser_out_buffer.sv
// -----------------------------------------------------------------------------
// deser_out_buffer
// One-entry valid/ready holding register for completed words. A word offered
// while the entry is full and not being drained is dropped and raises the
// sticky overrun flag.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   i_load           : a completed word is offered this cycle
//   i_word           : the completed word
//   i_parity_err     : parity error of that word (DESER_PARITY_EN only)
//   i_ready          : consumer accepts the held word
//   o_word, o_valid  : held word and its valid flag
//   o_overrun        : sticky, a word was dropped
//   o_parity_err     : parity error held with o_word (DESER_PARITY_EN only)
// Optional feature macro: DESER_PARITY_EN.
// -----------------------------------------------------------------------------
module deser_out_buffer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
`ifdef DESER_PARITY_EN
    input  logic             i_parity_err,
`endif
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun
`ifdef DESER_PARITY_EN
    ,
    output logic             o_parity_err
`endif
);

    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_overrun;
    logic             w_drain;
    logic             w_space;

    // The entry can take a new word if it is empty or emptying on this edge.
    assign w_drain = r_valid & i_ready;
    assign w_space = ~r_valid | i_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load && w_space) begin
                r_word  <= i_word;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (i_load && !w_space) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic r_parity_err;

    // Loaded alongside r_word so it stays qualified by o_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (i_load && w_space) begin
            r_parity_err <= i_parity_err;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    assign o_word    = r_word;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// serial_word_deserializer
// Receives an LSB-first bitstream on qualified strobes and assembles WIDTH-bit
// words, presented through a one-entry valid/ready buffer.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   serial_in    : serial data bit, sampled when bit_valid=1
//   bit_valid    : one bit consumed per cycle it is high
//   frame_start  : marks the sampled bit as bit 0 of a new word (resyncs)
//   word_out     : assembled word, bit 0 = first bit received
//   word_valid   : word_out holds an undelivered word
//   word_ready   : consumer accept
//   busy         : a frame is partially received
//   overrun      : sticky, a completed word was dropped (buffer full)
//   parity_err   : even-parity error of word_out (DESER_PARITY_EN only)
// Optional feature macro: DESER_PARITY_EN adds a trailing parity bit per frame.
// -----------------------------------------------------------------------------
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_word_deserializer: WIDTH out of range");
    end

    deser_state_t     r_state;
    deser_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
`ifdef DESER_PARITY_EN
    logic             w_parity_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_count_nxt  = r_count;
        w_complete   = 1'b0;
        w_word       = r_shift;
`ifdef DESER_PARITY_EN
        w_parity_err = 1'b0;
`endif
        if (bit_valid) begin
            if (frame_start) begin
                // New frame, or resync from any state: this bit is bit 0.
                // Older partial bits are cleared so they never leak into a word.
                w_state_nxt = ST_SHIFT;
                w_shift_nxt = {serial_in, {(WIDTH-1){1'b0}}};
                w_count_nxt = CNT_ONE;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        // Bits enter at the MSB and move down, so after WIDTH
                        // bits the first one received sits at bit 0.
                        w_shift_nxt = {serial_in, r_shift[WIDTH-1:1]};
                        if (r_count == CNT_LAST) begin
`ifdef DESER_PARITY_EN
                            w_state_nxt = ST_PARITY;
                            w_count_nxt = r_count + CNT_ONE;
`else
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                            w_complete  = 1'b1;
                            w_word      = {serial_in, r_shift[WIDTH-1:1]};
`endif
                        end else begin
                            w_count_nxt = r_count + CNT_ONE;
                        end
                    end
`ifdef DESER_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits XOR parity bit must be 0.
                        w_state_nxt  = ST_IDLE;
                        w_count_nxt  = '0;
                        w_complete   = 1'b1;
                        w_word       = r_shift;
                        w_parity_err = (^r_shift) ^ serial_in;
                    end
`endif
                    default: begin
                        // IDLE: a strobe without frame_start is ignored.
                    end
                endcase
            end
        end
    end

    deser_out_buffer #(
        .WIDTH        (WIDTH)
    ) u_out_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_complete),
        .i_word       (w_word),
`ifdef DESER_PARITY_EN
        .i_parity_err (w_parity_err),
`endif
        .i_ready      (word_ready),
        .o_word       (word_out),
        .o_valid      (word_valid),
        .o_overrun    (overrun)
`ifdef DESER_PARITY_EN
        ,
        .o_parity_err (parity_err)
`endif
    );

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_word_deserializer
// Directed bench for serial_word_deserializer (WIDTH=4). Expected words are
// queued when a frame is launched and compared when the word is handed over.
// Follows DESER_PARITY_EN for the parity bit and parity_err checks.
// -----------------------------------------------------------------------------
module tb_serial_word_deserializer;

    localparam int WIDTH = 4;
`ifdef DESER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             busy;
    logic             overrun;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .overrun     (overrun)
`ifdef DESER_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_cycle(input logic b, input logic fs);
        serial_in   = b;
        frame_start = fs;
        bit_valid   = 1'b1;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    // Pops the next expected word and compares it with what the DUT presents.
    task automatic compare_head(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_word"}, 32'(word_out), 32'(e.word));
`ifdef DESER_PARITY_EN
            check({tag, "_perr"}, 32'(parity_err), 32'(e.perr));
`endif
        end
    endtask

    // Sends one frame; optionally queues it as expected and drains the held
    // word on the edge that samples the final bit.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic bad_par,
                              input bit expect_store, input bit ready_on_last);
        logic b;
        if (expect_store) sb_q.push_back('{word: w, perr: bad_par});
        for (int i = 0; i < NBITS; i++) begin
            b = (i < WIDTH) ? w[i] : ((^w) ^ bad_par);
            if (i == NBITS - 1 && ready_on_last) begin
                compare_head("drain_on_load");
                word_ready = 1'b1;
            end
            bit_cycle(b, i == 0);
        end
        word_ready = 1'b0;
    endtask

    task automatic accept_word(input string tag);
        int n = 0;
        while (!word_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(word_valid), 32'(1));
        compare_head(tag);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(word_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        word_ready  = 1'b0;
        tick();
        tick();
        check("rst_word_out", 32'(word_out), 32'(0));
        check("rst_word_valid", 32'(word_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
`ifdef DESER_PARITY_EN
        check("rst_parity_err", 32'(parity_err), 32'(0));
`endif
        reset = 1'b0;
        tick();

        // Reset mid-frame after two bits aborts the frame.
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b0);
        check("midframe_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_valid", 32'(word_valid), 32'(0));
        tick();
        reset = 1'b0;
        tick();

        // Basic frame, consumer stalled, word held until accepted.
        send_frame(4'hD, 1'b0, 1'b1, 1'b0);
        check("basic_valid_latency", 32'(word_valid), 32'(1));
        check("basic_word", 32'(word_out), 32'(4'hD));
        check("basic_busy", 32'(busy), 32'(0));
        tick();
        tick();
        tick();
        check("basic_hold_valid", 32'(word_valid), 32'(1));
        check("basic_hold_word", 32'(word_out), 32'(4'hD));
        accept_word("basic");

        // Stray strobes in IDLE are ignored.
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        check("stray_busy", 32'(busy), 32'(0));
        check("stray_valid", 32'(word_valid), 32'(0));

        // Gapped strobes: 0..3 idle cycles between bits.
        begin
            logic [WIDTH-1:0] gw;
            logic             gb;
            gw = 4'hD;
            sb_q.push_back('{word: gw, perr: 1'b0});
            for (int i = 0; i < NBITS; i++) begin
                gb = (i < WIDTH) ? gw[i] : (^gw);
                bit_cycle(gb, i == 0);
                if (i < NBITS - 1) begin
                    check("gap_busy", 32'(busy), 32'(1));
                    repeat (i % 4) tick();
                end
            end
        end
        accept_word("gapped");

        // Overrun: second word dropped while the first is held.
        send_frame(4'hD, 1'b0, 1'b1, 1'b0);
        send_frame(4'h3, 1'b0, 1'b0, 1'b0);
        check("ovr_flag", 32'(overrun), 32'(1));
        check("ovr_word_kept", 32'(word_out), 32'(4'hD));
        accept_word("overrun");
        tick();
        check("ovr_sticky", 32'(overrun), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("ovr_cleared", 32'(overrun), 32'(0));

        // Drain and load on the same edge.
        send_frame(4'hD, 1'b0, 1'b1, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b1);
        check("sim_valid", 32'(word_valid), 32'(1));
        check("sim_overrun", 32'(overrun), 32'(0));
        accept_word("sim_new");

        // Resync after two bits.
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 1'b0);
        accept_word("resync");

        // Back-to-back frames with the second draining the first.
        send_frame(4'hA, 1'b0, 1'b1, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b1);
        check("b2b_overrun", 32'(overrun), 32'(0));
        accept_word("b2b");

`ifdef DESER_PARITY_EN
        // Bad parity is still delivered with parity_err set.
        send_frame(4'hD, 1'b1, 1'b1, 1'b0);
        accept_word("par_bad");
        send_frame(4'h7, 1'b0, 1'b1, 1'b0);
        accept_word("par_good");
`endif

        check("final_sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Serial-to-parallel receiver for the LSB-first bitstream produced by the team's shift-register serializers. It samples `serial_in` on qualified strobes and assembles `WIDTH`-bit words. Each completed word is presented on a one-entry valid/ready output buffer. It sits at the receive end of the serial link, feeding parallel consumers, and flags overrun when the consumer stalls.

## Interface
- `WIDTH`, default 4: data bits per word; legal range 2..32.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `serial_in` input 1: serial data bit; sampled only when `bit_valid`=1.
- `bit_valid` input 1: sample strobe; one bit is consumed per cycle in which it is high.
- `frame_start` input 1: qualifies the sampled bit as bit 0 of a new word; ignored when `bit_valid`=0.
- `word_out` output WIDTH: assembled word; bit 0 is the first bit received.
- `word_valid` output 1: `word_out` holds an undelivered word.
- `word_ready` input 1: consumer accepts; transfer occurs when `word_valid` and `word_ready` are both 1 at a clock edge.
- `busy` output 1: a frame is partially received (state is not IDLE).
- `overrun` output 1: sticky; a completed word was dropped because the buffer was full.
- `parity_err` output 1: present only with `DESER_PARITY_EN`; qualified by `word_valid`.

## Operation
- Reset values: `word_out`=0, `word_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0. The shift register and bit counter are cleared and the state is IDLE.
- States:
  - IDLE -> SHIFT on `bit_valid`&`frame_start`. The sampled bit is loaded and the count is set to 1.
  - In IDLE, `bit_valid` without `frame_start` is ignored.
  - SHIFT: each `bit_valid` does shift_reg <= {serial_in, shift_reg[WIDTH-1:1]} and count+1.
  - On the bit that makes the count equal WIDTH, the word completes and the state returns to IDLE (or goes to PARITY when the macro is enabled).
  - PARITY: the next `bit_valid` bit is the parity bit. The word completes and the state returns to IDLE.
- Resync: `bit_valid`&`frame_start` in SHIFT or PARITY discards the partial frame and restarts with this bit as bit 0, with count=1. No flag is raised.
- Word completion:
  - If the buffer is empty, or is being drained in the same cycle (`word_valid`&`word_ready`), the word loads into `word_out` and `word_valid`=1.
  - Otherwise the new word is dropped, `word_out` is unchanged, and `overrun` is set.
- `overrun` clears only on reset.
- `word_out` and `parity_err` stay stable while `word_valid`=1 and `word_ready`=0.
- The counter width is clog2(WIDTH+1). The counter does not wrap within a frame because completion always returns the state to IDLE.
- `reset` mid-frame aborts the frame immediately. A buffered undelivered word is lost.

## Timing
- Latency: `word_valid` rises in the cycle after the edge that samples the last bit (data bit WIDTH-1, or the parity bit).
- `bit_valid` may have arbitrary gaps, and the frame holds state indefinitely. Back-to-back frames are allowed: `frame_start` may arrive in the cycle right after completion.
- Maximum throughput is one word per WIDTH cycles (WIDTH+1 with parity). There is no backpressure on the serial side.
- `word_valid` falls in the cycle after an accepting edge unless a new word is loaded on that same edge. In that case it stays high with the new `word_out`.

## Configuration
- `DESER_PARITY_EN` defined:
  - Each frame carries one trailing even-parity bit, and the PARITY state exists.
  - `parity_err` = XOR(data bits, parity bit). It is registered with `word_out`.
  - A word with bad parity is still delivered.
- `DESER_PARITY_EN` undefined:
  - There is no PARITY state and no `parity_err` port.
  - The word completes on data bit WIDTH-1.

## Structure
- Package `deser_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - the state-encoding localparams;
  - the WIDTH legality limits (min 2, max 32).
- Sub-module `deser_out_buffer`:
  - one-entry valid/ready holding register with load, drain, and overrun detection;
  - parameterised on WIDTH, plus a parity bit when the macro is enabled.
- The top level contains the FSM, bit counter and shift register.

## Test plan
- Reset: assert `reset` mid-frame after 2 bits -> all outputs 0 and `busy`=0. The next full frame decodes correctly.
- Basic, WIDTH=4: bits 1,0,1,1 with `frame_start` on the first and `word_ready`=0 -> `word_out`=4'hD and `word_valid`=1 one cycle after the 4th bit. Both are held until `word_ready`=1, and `word_valid` drops the cycle after acceptance.
- Gapped strobes: the same bits with 0-3 idle cycles between `bit_valid` pulses -> 4'hD. Stray `bit_valid` in IDLE without `frame_start` -> ignored, `busy` stays 0.
- Overrun: `word_ready`=0, send 4'hD then 4'h3 -> `word_out` stays 4'hD and `overrun`=1 until reset.
- Simultaneous drain and load: 4'hD buffered, `word_ready`=1 on the edge where 4'h3 completes -> `word_out`=4'h3, `word_valid` stays 1, `overrun`=0. Resync: `frame_start` after 2 bits, then 0,1,1,0 -> 4'h6.
- `DESER_PARITY_EN`: data 1,0,1,1 then parity 1 -> 4'hD with `parity_err`=0. Parity 0 -> 4'hD with `parity_err`=1.
